sqrt_job_dispatcher: RTL and testbench

//  Upstream feeder for squareroot_f32_approximation. Queues FP32 operands and tags, and resolves IEEE special cases locally.

---
 rtl/pe_fp32_pkg.sv | 57 +++++
 rtl/pe_sync_fifo.sv | 50 +++++
 rtl/sqrt_job_dispatcher.sv | 183 ++++++++++++++++++
 tb/tb_sqrt_job_dispatcher.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_fp32_pkg.sv
// Shared FP32 constants, operand classification helpers and the sqrt dispatcher state encoding.
package pe_fp32_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [FP_W-1:0] QNAN  = 32'h7FC0_0000;
  localparam logic [FP_W-1:0] PINF  = 32'h7F80_0000;
  localparam logic [FP_W-1:0] PZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] NZERO = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } disp_state_e;

  typedef struct packed {
    logic neg;
    logic zero;
    logic denorm;
    logic inf;
    logic nan;
  } fp_class_t;

  function automatic fp_class_t fp_classify(input logic [FP_W-1:0] v);
    fp_class_t        c;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e        = v[FP_W-2 -: EXP_W];
    m        = v[MAN_W-1:0];
    c.neg    = v[FP_W-1];
    c.zero   = (e == '0) && (m == '0);
    c.denorm = (e == '0) && (m != '0);
    c.inf    = (e == '1) && (m == '0);
    c.nan    = (e == '1) && (m != '0);
    return c;
  endfunction

  function automatic logic fp_is_special(input fp_class_t c);
    return c.neg | c.zero | c.denorm | c.inf | c.nan;
  endfunction

  // Zero/denorm checked before sign so that -0 and negative denormals keep their sign.
  function automatic logic [FP_W-1:0] fp_special_result(input fp_class_t c);
    logic [FP_W-1:0] r;
    r = PZERO;
    if (c.nan)                    r = QNAN;
    else if (c.zero || c.denorm)  r = c.neg ? NZERO : PZERO;
    else if (c.neg)               r = QNAN;
    else if (c.inf)               r = PINF;
    return r;
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO, DEPTH (power of 2) x W, wrap-bit full/empty.
// Latency: write visible at pop_dat the cycle after push; pop_dat combinational from head.
// Backpressure: push ignored while full, pop ignored while empty; simultaneous push+pop legal.
module pe_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         full,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/sqrt_job_dispatcher.sv
// Queues tagged FP32 sqrt jobs for one external core (one in flight); IEEE specials bypass the core.
// Latency: bypass push->out_valid 2 cycles; core path push->RUN 2+RST_CYC cycles plus core time.
// Backpressure: in_ready=!fifo_full (DEPTH queued + 1 held in DONE); out_valid held until out_ready.
// Optional SQRT_DISP_TIMEOUT_EN: abort RUN after TIMEOUT cycles with out_err=1 and a quiet NaN.
module sqrt_job_dispatcher
  import pe_fp32_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             core_rst,
  output logic [31:0]      core_a,
  input  logic             core_rdy,
  input  logic [31:0]      core_sqrt
);

  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RST_CYC < 1 || TIMEOUT < 1) begin : g_param_check
    $error("sqrt_job_dispatcher: illegal parameter set");
  end

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [FP_W-1:0]  dat;
  } job_t;

  job_t      push_job, pop_job;
  logic      fifo_full, fifo_empty, fifo_pop;
  fp_class_t op_cls;

  disp_state_e      state_q, state_d;
  logic [RC_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [FP_W-1:0]  core_a_q, core_a_d;
  logic [FP_W-1:0]  out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_valid_q, out_valid_d;
  logic             core_rst_q, core_rst_d;
  logic             in_en_q, in_en_d;
`ifdef SQRT_DISP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             out_err_q, out_err_d;
`endif

  assign push_job = '{tag: in_tag, dat: in_data};
  // in_en_q keeps the input closed for the first cycle after reset releases.
  assign in_ready = in_en_q && !fifo_full;
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
  assign op_cls   = fp_classify(pop_job.dat);

  pe_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (FP_W + TAG_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (in_valid && in_ready),
    .push_dat (push_job),
    .full     (fifo_full),
    .pop_rdy  (fifo_pop),
    .pop_dat  (pop_job),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    core_a_d   = core_a_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    in_en_d    = 1'b1;
`ifdef SQRT_DISP_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    out_err_d  = out_err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          out_tag_d = pop_job.tag;
`ifdef SQRT_DISP_TIMEOUT_EN
          out_err_d = 1'b0;
`endif
          if (fp_is_special(op_cls)) begin
            out_data_d = fp_special_result(op_cls);
            state_d    = ST_DONE;
          end else begin
            core_a_d = pop_job.dat;
            ld_cnt_d = '0;
            state_d  = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (ld_cnt_q == RC_W'(RST_CYC - 1)) begin
          state_d = ST_RUN;
`ifdef SQRT_DISP_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (core_rdy) begin
          out_data_d = core_sqrt;
          state_d    = ST_DONE;
        end
`ifdef SQRT_DISP_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          out_data_d = QNAN;
          out_err_d  = 1'b1;
          state_d    = ST_DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    out_valid_d = (state_d == ST_DONE);
    core_rst_d  = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ld_cnt_q    <= '0;
      core_a_q    <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
      core_rst_q  <= 1'b1;
      in_en_q     <= 1'b0;
`ifdef SQRT_DISP_TIMEOUT_EN
      to_cnt_q    <= '0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      core_a_q    <= core_a_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      core_rst_q  <= core_rst_d;
      in_en_q     <= in_en_d;
`ifdef SQRT_DISP_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign core_rst  = core_rst_q;
  assign core_a    = core_a_q;
`ifdef SQRT_DISP_TIMEOUT_EN
  assign out_err   = out_err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_job_dispatcher.sv
// Self-checking bench for sqrt_job_dispatcher with a behavioural sqrt core stub and a result scoreboard.
module tb_sqrt_job_dispatcher;

  localparam int DEPTH      = 4;
  localparam int TAG_W      = 4;
  localparam int RST_CYC    = 2;
  localparam int TB_TIMEOUT = 64;
  localparam int CORE_LAT   = 3;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [31:0]      dat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             core_rst;
  logic [31:0]      core_a;
  logic             core_rdy = 1'b0;
  logic [31:0]      core_sqrt = '0;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  bit   stub_hang = 1'b0;
  int   stub_cnt = 0;

  sqrt_job_dispatcher #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .RST_CYC (RST_CYC),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .core_rst  (core_rst),
    .core_a    (core_a),
    .core_rdy  (core_rdy),
    .core_sqrt (core_sqrt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference square roots (correctly rounded FP32) for the operands the bench uses.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
    case (a)
      32'h3F80_0000: return 32'h3F80_0000;
      32'h4000_0000: return 32'h3FB5_04F3;
      32'h4040_0000: return 32'h3FDD_B3D7;
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      default:       return 32'h0BAD_0BAD;
    endcase
  endfunction

  // Core stub: held idle by core_rst, answers CORE_LAT cycles after release and holds rdy.
  always @(negedge clk) begin
    if (core_rst) begin
      stub_cnt  = 0;
      core_rdy  = 1'b0;
      core_sqrt = '0;
    end else if (stub_hang) begin
      core_rdy = 1'b0;
    end else if (stub_cnt == CORE_LAT) begin
      core_rdy  = 1'b1;
      core_sqrt = ref_sqrt(core_a);
    end else begin
      stub_cnt++;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the job.
  task automatic push(input logic [31:0] d, input logic [TAG_W-1:0] t,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) begin
      sb_q.push_back({exp_e, t, exp_d});
    end else begin
      total++;
      bad++;
      $display("FAIL push_stall in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b required=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h required=0", out_data); end
    total++; if (out_tag !== '0) begin bad++; $display("FAIL rst_out_tag got=%h required=0", out_tag); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got=%0b required=0", out_err); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL rst_core_rst got=%0b required=1", core_rst); end
    total++; if (core_a !== 32'h0) begin bad++; $display("FAIL rst_core_a got=%h required=0", core_a); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b required=0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_release_in_ready got=%0b required=0", in_ready); end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_after_in_ready got=%0b required=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_core_single();
    exp_t e;
    int   n;
    push(32'h4000_0000, 4'd3, 32'h3FB5_04F3, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_rst && n < 50);
    total++; if (n !== 2 + RST_CYC) begin bad++; $display("FAIL core_launch_latency got=%0d required=%0d", n, 2 + RST_CYC); end
    out_ready = 1'b1;
    for (int k = 0; k < 300 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb_q.pop_front();
        total++;
        if ({out_err, out_tag, out_data} !== e) begin
          bad++; $display("FAIL core_result got err=%0b tag=%h data=%h required err=%0b tag=%h data=%h", out_err, out_tag, out_data, e.err, e.tag, e.dat);
        end
      end
    end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL core_drain left=%0d required=0", sb_q.size()); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h4040_0000;
    in_tag    = 4'd1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept1 got=%0b required=1", in_ready); end
    sb_q.push_back({1'b0, 4'd1, 32'h3FDD_B3D7});
    @(posedge clk); #1;
    in_data = 32'h4080_0000;
    in_tag  = 4'd2;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept2 got=%0b required=1", in_ready); end
    sb_q.push_back({1'b0, 4'd2, 32'h4000_0000});
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 300 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb_q.pop_front();
        total++;
        if ({out_err, out_tag, out_data} !== e) begin
          bad++; $display("FAIL b2b_result got err=%0b tag=%h data=%h required err=%0b tag=%h data=%h", out_err, out_tag, out_data, e.err, e.tag, e.dat);
        end
      end
    end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL b2b_drain left=%0d required=0", sb_q.size()); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_specials();
    logic [31:0] sp_in  [8];
    logic [31:0] sp_out [8];
    exp_t        e;
    logic        rst_ok;
    sp_in  = '{32'hC080_0000, 32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0001,
               32'h0000_0001, 32'hFF80_0000, 32'h8000_0001, 32'h0000_0000};
    sp_out = '{QNAN, 32'h8000_0000, 32'h7F80_0000, QNAN,
               32'h0000_0000, QNAN, 32'h8000_0000, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      push(sp_in[i], TAG_W'(i), sp_out[i], 1'b0);
      @(negedge clk);
      rst_ok = core_rst;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL spec_early[%0d] out_valid=%0b required=0", i, out_valid); end
      @(negedge clk);
      rst_ok = rst_ok & core_rst;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL spec_latency[%0d] out_valid=%0b required=1", i, out_valid); end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if ({out_err, out_tag, out_data} !== e) begin
          bad++; $display("FAIL spec_result[%0d] got err=%0b tag=%h data=%h required err=%0b tag=%h data=%h", i, out_err, out_tag, out_data, e.err, e.tag, e.dat);
        end
      end
      total++; if (rst_ok !== 1'b1) begin bad++; $display("FAIL spec_core_rst[%0d] got=%0b required=1", i, rst_ok); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_capacity();
    exp_t e;
    int   acc;
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      // Denormal operands: result is a zero carrying the operand's sign.
      in_data = {acc[0], 8'h00, 23'(acc + 1)};
      in_tag  = TAG_W'(acc + 8);
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back({1'b0, TAG_W'(acc + 8), acc[0], 31'b0});
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (acc !== DEPTH + 1) begin bad++; $display("FAIL cap_accepted got=%0d required=%0d", acc, DEPTH + 1); end
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL cap_in_ready got=%0b required=0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL cap_held_valid got=%0b required=1", out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 300 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb_q.pop_front();
        total++;
        if ({out_err, out_tag, out_data} !== e) begin
          bad++; $display("FAIL cap_result got err=%0b tag=%h data=%h required err=%0b tag=%h data=%h", out_err, out_tag, out_data, e.err, e.tag, e.dat);
        end
      end
    end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL cap_drain left=%0d required=0", sb_q.size()); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

`ifdef SQRT_DISP_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int   n;
    int   runs;
    stub_hang = 1'b1;
    push(32'h4000_0000, 4'd5, QNAN, 1'b1);
    n = 0;
    runs = 0;
    do begin
      @(negedge clk);
      n++;
      if (!core_rst) runs++;
    end while (!out_valid && n < TB_TIMEOUT + 50);
    total++; if (runs !== TB_TIMEOUT) begin bad++; $display("FAIL timeout_run_cycles got=%0d required=%0d", runs, TB_TIMEOUT); end
    stub_hang = 1'b0;
    @(posedge clk); #1;
    push(32'h4110_0000, 4'd6, 32'h4040_0000, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 300 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb_q.pop_front();
        total++;
        if ({out_err, out_tag, out_data} !== e) begin
          bad++; $display("FAIL timeout_result got err=%0b tag=%h data=%h required err=%0b tag=%h data=%h", out_err, out_tag, out_data, e.err, e.tag, e.dat);
        end
      end
    end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL timeout_drain left=%0d required=0", sb_q.size()); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_run();
    exp_t e;
    int   n;
    logic stale;
    logic launched;
    push(32'h4080_0000, 4'd7, 32'h4000_0000, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (core_rst && n < 50);
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL midrun_launch core_rst=%0b required=0", core_rst); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrun_out_valid got=%0b required=0", out_valid); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL midrun_core_rst got=%0b required=1", core_rst); end
    out_ready = 1'b1;
    stale = 1'b0;
    launched = 1'b0;
    repeat (20) begin
      @(negedge clk);
      stale = stale | out_valid;
      launched = launched | !core_rst;
    end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL midrun_stale_output got=%0b required=0", stale); end
    total++; if (launched !== 1'b0) begin bad++; $display("FAIL midrun_fifo_not_empty launched=%0b required=0", launched); end
    @(posedge clk); #1;
    push(32'h3F80_0000, 4'd9, 32'h3F80_0000, 1'b0);
    for (int k = 0; k < 300 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb_q.pop_front();
        total++;
        if ({out_err, out_tag, out_data} !== e) begin
          bad++; $display("FAIL midrun_next_result got err=%0b tag=%h data=%h required err=%0b tag=%h data=%h", out_err, out_tag, out_data, e.err, e.tag, e.dat);
        end
      end
    end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL midrun_drain left=%0d required=0", sb_q.size()); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_core_single();
    test_back_to_back();
    test_specials();
    test_capacity();
`ifdef SQRT_DISP_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
